mm_iddmm_res_collect: RTL and testbench

- Consumer/initiator on the far side of the IDDMM final compare-subtract result interface.
- Issues the one-cycle task request and captures the low-word-first result stream (res/res_val/task_end) into a destination RAM (e.g. operand X RAM for the next modexp iteration).
- Checks the word count, flags the result value one, and hands a done/err status back to the modexp controller.

---
 rtl/mm_iddmm_pkg.sv | 14 +
 rtl/mm_iddmm_res_collect_if.sv | 14 +
 rtl/mm_iddmm_res_collect.sv | 149 ++++++++++++++
 tb/tb_mm_iddmm_res_collect.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_iddmm_pkg.sv
// Shared definitions for the IDDMM result-collection path: FSM encoding and size defaults.
package mm_iddmm_pkg;

  localparam int unsigned KDefault = 128;
  localparam int unsigned NDefault = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StCollect = 2'd2,
    StDone    = 2'd3
  } state_e;

endpackage

// File: rtl/mm_iddmm_res_collect_if.sv
// Request/result-stream link between the collector (master) and the compare-subtract block.
interface mm_iddmm_res_collect_if
  import mm_iddmm_pkg::*;
#(
    parameter int unsigned K = KDefault
);
    logic         task_req;
    logic [K-1:0] res;
    logic         res_val;
    logic         task_end;

    modport master (output task_req, input res, input res_val, input task_end);
    modport slave  (input task_req, output res, output res_val, output task_end);
endinterface

// File: rtl/mm_iddmm_res_collect.sv
// Requests one IDDMM result, writes its words low-first into a RAM and reports done/err/is-one.
module mm_iddmm_res_collect
  import mm_iddmm_pkg::*;
#(
    parameter int unsigned K       = KDefault,
    parameter int unsigned N       = NDefault,
    parameter int unsigned ADDR_W  = $clog2(N),
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  res_is_one_o,
    mm_iddmm_res_collect_if.master res_if,
    output logic                  wr_en_o,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic [K-1:0]          wr_data_o
);

    localparam int unsigned CW = ADDR_W + 1;
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] NCnt   = CW'(N);
    localparam logic [TW-1:0] TmoMax = TW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              one_q, one_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              is_one_q, is_one_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [K-1:0]      wr_data_q, wr_data_d;
    logic              busy_q, done_q, task_req_q;
    logic              word_ok;

    // Word 0 of a unity result is 1; every higher word is 0.
    assign word_ok = (cnt_q == '0) ? (res_if.res == K'(1)) : (res_if.res == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        one_d     = one_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        is_one_d  = is_one_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StReq;
                    cnt_d    = '0;
                    tmo_d    = '0;
                    one_d    = 1'b1;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    is_one_d = 1'b0;
                end
            end
            StReq: begin
                // The request cycle already counts toward the response timeout.
                state_d = StCollect;
                tmo_d   = tmo_q + 1'b1;
            end
            StCollect: begin
                if (res_if.res_val) begin
                    if (cnt_q < NCnt) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cnt_q[ADDR_W-1:0];
                        wr_data_d = res_if.res;
                        cnt_d     = cnt_q + 1'b1;
                        one_d     = one_q & word_ok;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (res_if.res_val || res_if.task_end) begin
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
                if (res_if.task_end) begin
                    state_d  = StDone;
                    err_d    = ovf_d | (cnt_d != NCnt);
                    is_one_d = one_d & ~(ovf_d | (cnt_d != NCnt));
                end else if (!res_if.res_val && (tmo_q == TmoMax)) begin
                    state_d  = StDone;
                    err_d    = 1'b1;
                    is_one_d = 1'b0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tmo_q      <= '0;
            one_q      <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            is_one_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            task_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            one_q      <= one_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            is_one_q   <= is_one_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= (state_d != StIdle);
            done_q     <= (state_d == StDone);
            task_req_q <= (state_d == StReq);
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign res_is_one_o    = is_one_q;
    assign res_if.task_req = task_req_q;
    assign wr_en_o         = wr_en_q;
    assign wr_addr_o       = wr_addr_q;
    assign wr_data_o       = wr_data_q;

endmodule

// File: tb/tb_mm_iddmm_res_collect.sv
// Bench for mm_iddmm_res_collect: vector table of result streams, write scoreboard, corner sequences.
module tb_mm_iddmm_res_collect;

    localparam int unsigned K = 128;
    localparam int unsigned N = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned TMO = 16;

    typedef struct {
        int           nw;
        logic [K-1:0] w [6];
        int           gap;
        int           edly;
        bit           eerr;
        bit           eone;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [K-1:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, err, res_is_one, wr_en;
    logic [AW-1:0] wr_addr;
    logic [K-1:0]  wr_data;

    int total = 0;
    int bad = 0;
    wr_t exp_q[$];
    vec_t v[6];

    mm_iddmm_res_collect_if #(.K(K)) rif ();

    mm_iddmm_res_collect #(.K(K), .N(N), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .res_is_one_o (res_is_one),
        .res_if       (rif),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every RAM write must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected none", wr_addr,
                         wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", K'(wr_addr), K'(e.addr));
                chk("wr_data", wr_data, e.data);
            end
        end
    end

    function automatic vec_t mk(input int nw, input logic [K-1:0] a, input logic [K-1:0] b,
                                input logic [K-1:0] c, input logic [K-1:0] d,
                                input logic [K-1:0] e, input int gap, input int edly,
                                input bit eerr, input bit eone);
        vec_t r;
        r.nw = nw;
        r.w[0] = a; r.w[1] = b; r.w[2] = c; r.w[3] = d; r.w[4] = e; r.w[5] = '0;
        r.gap = gap;
        r.edly = edly;
        r.eerr = eerr;
        r.eone = eone;
        return r;
    endfunction

    task automatic do_start(output bit ok);
        ok = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 8; t++) begin
            if (rif.task_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("task_req_seen", K'(ok), K'(1));
        chk("busy_at_req", K'(busy), K'(1));
        @(negedge clk);
    endtask

    task automatic send_word(input logic [K-1:0] w, input int idx, input bit last_end);
        wr_t e;
        rif.res_val = 1'b1;
        rif.res = w;
        rif.task_end = last_end;
        if (idx < N) begin
            e.addr = AW'(idx);
            e.data = w;
            exp_q.push_back(e);
        end
        @(negedge clk);
        rif.res_val = 1'b0;
        rif.task_end = 1'b0;
        rif.res = '0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", K'(done), K'(1));
    endtask

    task automatic run_vec(input vec_t x);
        bit ok;
        int cyc;
        do_start(ok);
        for (int i = 0; i < x.nw; i++) begin
            send_word(x.w[i], i, (x.edly == 0) && (i == x.nw - 1));
            if (i != x.nw - 1) repeat (x.gap - 1) @(negedge clk);
        end
        if (x.edly > 0) begin
            repeat (x.edly - 1) @(negedge clk);
            rif.task_end = 1'b1;
            @(negedge clk);
            rif.task_end = 1'b0;
        end
        wait_done(cyc);
        chk("err", K'(err), K'(x.eerr));
        chk("res_is_one", K'(res_is_one), K'(x.eone));
        @(negedge clk);
        chk("done_pulse", K'(done), K'(0));
        chk("busy_after", K'(busy), K'(0));
        chk("err_held", K'(err), K'(x.eerr));
        chk("writes_drained", K'(exp_q.size()), K'(0));
        exp_q.delete();
    endtask

    initial begin
        bit ok;
        int cyc;
        rif.res = '0;
        rif.res_val = 1'b0;
        rif.task_end = 1'b0;

        v[0] = mk(4, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        v[1] = mk(4, 'h5, 'hA, 'hF, 'h3, 0, 2, 1, 0, 0);
        v[2] = mk(3, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        v[3] = mk(5, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        v[4] = mk(4, 1, 0, 2, 0, 0, 1, 0, 0, 0);
        v[5] = mk(4, 2, 0, 0, 0, 0, 3, 2, 0, 0);

        repeat (2) @(negedge clk);
        chk("rst_busy", K'(busy), K'(0));
        chk("rst_done", K'(done), K'(0));
        chk("rst_err", K'(err), K'(0));
        chk("rst_one", K'(res_is_one), K'(0));
        chk("rst_task_req", K'(rif.task_req), K'(0));
        chk("rst_wr_en", K'(wr_en), K'(0));
        chk("rst_wr_addr", K'(wr_addr), K'(0));
        chk("rst_wr_data", wr_data, K'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Stream activity while idle must not write.
        rif.res_val = 1'b1;
        rif.task_end = 1'b1;
        rif.res = 'h77;
        repeat (3) @(negedge clk);
        rif.res_val = 1'b0;
        rif.task_end = 1'b0;
        chk("idle_busy", K'(busy), K'(0));

        for (int i = 0; i < 6; i++) run_vec(v[i]);

        // No response at all: timeout fires 16 cycles after the request.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("tmo_task_req", K'(rif.task_req), K'(1));
        wait_done(cyc);
        chk("tmo_latency", K'(cyc), K'(16));
        chk("tmo_err", K'(err), K'(1));
        chk("tmo_one", K'(res_is_one), K'(0));
        @(negedge clk);

        // Re-start mid-collect is ignored, then reset mid-stream.
        do_start(ok);
        send_word(1, 0, 1'b0);
        send_word(0, 1, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 3; t++) begin
            chk("no_rereq", K'(rif.task_req), K'(0));
            @(negedge clk);
        end
        chk("busy_mid", K'(busy), K'(1));
        chk("mid_writes", K'(exp_q.size()), K'(0));
        rif.res_val = 1'b1;
        rif.res = 'h9;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_busy", K'(busy), K'(0));
        chk("mrst_wr_en", K'(wr_en), K'(0));
        chk("mrst_done", K'(done), K'(0));
        chk("mrst_err", K'(err), K'(0));
        chk("mrst_wr_addr", K'(wr_addr), K'(0));
        rst_n = 1'b1;
        rif.task_end = 1'b1;
        repeat (4) @(negedge clk);
        rif.res_val = 1'b0;
        rif.task_end = 1'b0;
        chk("post_rst_busy", K'(busy), K'(0));
        chk("post_rst_done", K'(done), K'(0));
        run_vec(v[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
